aq_djpeg_infifo: RTL and testbench
==================================

Name: aq_djpeg_infifo

Overview:
- Input buffer directly upstream of the JPEG register/bit-aligner stage.
- Accepts the compressed JPEG byte stream as a 32-bit AXI4-Stream slave and stores it in a first-word-fall-through FIFO.
- Presents words on the DataIn/DataInEnable/DataInRead interface and gates the stream to one image at a time.
- Discards any trailing bytes left after the end-of-image marker once the decoder reports end and idle.

Parameters:
- ADDR_WIDTH, 4, FIFO depth = 2**ADDR_WIDTH words (default 16).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- s_axis_tdata  input  32  stream data; byte 0 (first in file) on [7:0].
- s_axis_tkeep  input  4  byte enables; bit n qualifies byte n.
- s_axis_tvalid  input  1  stream valid.
- s_axis_tlast  input  1  last word of the image.
- s_axis_tready  output  1  stream ready.
- DataIn  output  32  FIFO head word, byte order unchanged.
- DataInEnable  output  1  head word valid (FIFO not empty).
- DataInRead  input  1  pop the head word this cycle.
- DataInReq  input  1  downstream is requesting data (statistics only).
- DataOutEnd  input  1  downstream has detected the EOI marker.
- ProcessIdle  input  1  decoder is idle.
- Level  output  ADDR_WIDTH+1  current FIFO occupancy in words.

Behaviour:
- Reset values:
  - s_axis_tready=0 during reset, then follows the state rule below.
  - DataInEnable=0, DataIn=0, Level=0.
  - Pointers = 0, state = STREAM.
- Storage:
  - Register array indexed by wr_ptr/rd_ptr, each ADDR_WIDTH+1 bits with a wrap bit.
  - full when the low bits are equal and the wrap bits differ; empty when the pointers are equal.
  - Level = wr_ptr - rd_ptr, modulo 2**(ADDR_WIDTH+1).
- Write:
  - Occurs on tvalid & tready in STREAM.
  - Bytes with tkeep[n]=0 are replaced by 8'hFF (JPEG fill byte).
  - A beat with tkeep=4'b0000 is not written, but its tlast still takes effect.
- Read:
  - DataIn shows mem[rd_ptr] combinationally; DataInEnable = !empty.
  - DataInRead while empty is ignored; no pointer change.
- Latency: a word written at edge N is visible on DataIn with DataInEnable=1 in the cycle after edge N.
- Simultaneous push and pop: Level unchanged.
- Full: tready=0.
  - A pop while full raises tready the next cycle; there is no combinational pop-to-ready path.
- tready is decoded from registered state and pointers only:
  - STREAM: tready = !full.
  - DISCARD: tready = 1.
  - DRAIN and FLUSH: tready = 0.
- State machine:
  - STREAM: accept data.
    - Accepted tlast -> DRAIN.
    - DataOutEnd & ProcessIdle before tlast -> DISCARD, with the FIFO cleared on that edge.
  - DRAIN: hold input. DataOutEnd & ProcessIdle -> FLUSH.
  - DISCARD: accept and drop every beat. Accepted tlast -> FLUSH.
  - FLUSH: one cycle; rd_ptr <= wr_ptr (leftover words dropped, DataInEnable=0) -> STREAM.
- Simultaneous events:
  - tlast accepted in STREAM on the same edge as DataOutEnd & ProcessIdle: go to FLUSH. The tlast word is not written.
  - DataInRead in FLUSH is ignored.
- Reset asserted mid-image: all state cleared immediately; partial data is lost.

Optional Feature:
- Macro: AQ_DJPEG_INFIFO_STAT_EN.
- Defined: adds the outputs StatBytes[31:0] and StatUnderrun[31:0].
  - StatBytes adds popcount(tkeep) per written beat.
  - StatUnderrun increments on each cycle with DataInReq=1 & empty & state!=FLUSH.
  - Both counters saturate at 32'hFFFFFFFF and clear on reset and on entry to FLUSH.
- Not defined: neither the ports nor the logic exist.

Test Plan:
- Reset then push 3 beats 32'hE0FFD8FF, 32'h11223344, 32'h55667788 back-to-back -> Level=3; DataIn=32'hE0FFD8FF the cycle after the first handshake; three pops return the words in order; DataInEnable=0 after the third pop.
- Push 16 beats with no reads (ADDR_WIDTH=4) -> tready=0 at Level=16; one pop -> tready=1 on the next cycle, never on the same cycle.
- Last beat tdata=32'hAABBD9FF, tkeep=4'b0011, tlast=1 -> stored word 32'hFFFFD9FF; state DRAIN, tready=0.
- From DRAIN with 2 words left, pulse DataOutEnd=1 & ProcessIdle=1 -> FLUSH for one cycle, DataInEnable=0, Level=0, then STREAM with tready=1.
- End/idle asserted in STREAM after 5 of 10 beats -> beats 6 to 10 are accepted but Level stays 0; tlast -> FLUSH -> STREAM; the next image's first word appears intact.
- With AQ_DJPEG_INFIFO_STAT_EN: 4 beats with tkeep 4'hF,4'hF,4'hF,4'h1 -> StatBytes=13; 7 cycles with DataInReq=1 while empty -> StatUnderrun=7.

Source files
------------

// File: rtl/aq_djpeg_infifo.sv
// First-word-fall-through input FIFO that gates the JPEG byte stream to one image at a time.
// Optional statistics counters are enabled by defining AQ_DJPEG_INFIFO_STAT_EN.
module aq_djpeg_infifo #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           s_axis_tdata,
    input  logic [3:0]            s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [31:0]           DataIn,
    output logic                  DataInEnable,
    input  logic                  DataInRead,
    input  logic                  DataInReq,
    input  logic                  DataOutEnd,
    input  logic                  ProcessIdle,
`ifdef AQ_DJPEG_INFIFO_STAT_EN
    output logic [31:0]           StatBytes,
    output logic [31:0]           StatUnderrun,
`endif
    output logic [ADDR_WIDTH:0]   Level
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_STREAM  = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DISCARD = 2'd2,
        ST_FLUSH   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_run;
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [31:0]           r_mem [DEPTH];

    logic                  w_full;
    logic                  w_empty;
    logic                  w_acc;
    logic                  w_end_idle;
    logic                  w_wr_en;
    logic                  w_clear;
    logic                  w_pop;
    logic                  w_to_flush;
    logic                  w_has_bytes;
    logic [31:0]           w_wdata;

    assign w_full  = (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]) &&
                     (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    // r_run holds tready low while reset is asserted and until the first edge after release
    always_comb begin
        s_axis_tready = 1'b0;
        if (r_run) begin
            case (r_state)
                ST_STREAM:  s_axis_tready = !w_full;
                ST_DISCARD: s_axis_tready = 1'b1;
                default:    s_axis_tready = 1'b0;
            endcase
        end
    end

    assign w_acc       = s_axis_tvalid && s_axis_tready;
    assign w_end_idle  = DataOutEnd && ProcessIdle;
    assign w_has_bytes = |s_axis_tkeep;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_fill
            assign w_wdata[8*gi +: 8] = s_axis_tkeep[gi] ? s_axis_tdata[8*gi +: 8] : 8'hFF;
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_wr_en      = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            ST_STREAM: begin
                if (w_acc && s_axis_tlast && w_end_idle) begin
                    w_clear      = 1'b1;
                    w_state_next = ST_FLUSH;
                end else if (w_acc && s_axis_tlast) begin
                    w_wr_en      = w_has_bytes;
                    w_state_next = ST_DRAIN;
                end else if (w_end_idle) begin
                    w_clear      = 1'b1;
                    w_state_next = ST_DISCARD;
                end else begin
                    w_wr_en      = w_acc && w_has_bytes;
                end
            end
            ST_DRAIN: begin
                if (w_end_idle) begin
                    w_clear      = 1'b1;
                    w_state_next = ST_FLUSH;
                end
            end
            ST_DISCARD: begin
                if (w_acc && s_axis_tlast) begin
                    w_clear      = 1'b1;
                    w_state_next = ST_FLUSH;
                end
            end
            default: begin
                w_clear      = 1'b1;
                w_state_next = ST_STREAM;
            end
        endcase
    end

    // Clearing (which covers the whole FLUSH cycle) overrides any pop
    assign w_pop      = DataInRead && !w_empty && !w_clear;
    assign w_to_flush = (w_state_next == ST_FLUSH) && (r_state != ST_FLUSH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_STREAM;
            r_run    <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_state <= w_state_next;
            r_run   <= 1'b1;
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_clear) begin
                r_rd_ptr <= r_wr_ptr;
            end else if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= w_wdata;
        end
    end

    assign DataIn       = w_empty ? 32'h0 : r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
    assign DataInEnable = !w_empty;
    assign Level        = r_wr_ptr - r_rd_ptr;

`ifdef AQ_DJPEG_INFIFO_STAT_EN
    logic [31:0] r_stat_bytes;
    logic [31:0] r_stat_underrun;
    logic [2:0]  w_popcnt;
    logic [32:0] w_bytes_sum;

    assign w_popcnt    = {2'b0, s_axis_tkeep[0]} + {2'b0, s_axis_tkeep[1]} +
                         {2'b0, s_axis_tkeep[2]} + {2'b0, s_axis_tkeep[3]};
    assign w_bytes_sum = {1'b0, r_stat_bytes} + {30'b0, w_popcnt};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stat_bytes    <= '0;
            r_stat_underrun <= '0;
        end else if (w_to_flush) begin
            r_stat_bytes    <= '0;
            r_stat_underrun <= '0;
        end else begin
            if (w_wr_en) begin
                r_stat_bytes <= w_bytes_sum[32] ? 32'hFFFF_FFFF : w_bytes_sum[31:0];
            end
            if (DataInReq && w_empty && (r_state != ST_FLUSH) &&
                (r_stat_underrun != 32'hFFFF_FFFF)) begin
                r_stat_underrun <= r_stat_underrun + 32'd1;
            end
        end
    end

    assign StatBytes    = r_stat_bytes;
    assign StatUnderrun = r_stat_underrun;
`else
    logic w_unused_req;
    logic w_unused_flush;
    assign w_unused_req   = DataInReq;
    assign w_unused_flush = w_to_flush;
`endif

endmodule

// File: tb/tb_aq_djpeg_infifo.sv
// Directed plus randomized bench for aq_djpeg_infifo against a queue-based reference model.
module tb_aq_djpeg_infifo;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int M_STREAM  = 0;
    localparam int M_DRAIN   = 1;
    localparam int M_DISCARD = 2;
    localparam int M_FLUSH   = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [31:0]   s_axis_tdata = '0;
    logic [3:0]    s_axis_tkeep = 4'hF;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tready;
    logic [31:0]   DataIn;
    logic          DataInEnable;
    logic          DataInRead = 1'b0;
    logic          DataInReq = 1'b0;
    logic          DataOutEnd = 1'b0;
    logic          ProcessIdle = 1'b0;
    logic [AW:0]   Level;
`ifdef AQ_DJPEG_INFIFO_STAT_EN
    logic [31:0]   StatBytes;
    logic [31:0]   StatUnderrun;
`endif

    aq_djpeg_infifo #(.ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .DataIn        (DataIn),
        .DataInEnable  (DataInEnable),
        .DataInRead    (DataInRead),
        .DataInReq     (DataInReq),
        .DataOutEnd    (DataOutEnd),
        .ProcessIdle   (ProcessIdle),
`ifdef AQ_DJPEG_INFIFO_STAT_EN
        .StatBytes     (StatBytes),
        .StatUnderrun  (StatUnderrun),
`endif
        .Level         (Level)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: image phase, queue of stored words, statistics
    logic [31:0] q[$];
    int          mstate;
    bit          mrun;
    logic [31:0] m_bytes;
    logic [31:0] m_under;

    function automatic logic [31:0] fill(input logic [31:0] d, input logic [3:0] k);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = k[i] ? d[8*i +: 8] : 8'hFF;
        return r;
    endfunction

    function automatic bit exp_ready();
        if (!mrun) return 1'b0;
        if (mstate == M_STREAM) return q.size() < DEPTH;
        return mstate == M_DISCARD;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        chk("level",  32'(Level), 32'(q.size()));
        chk("enable", 32'(DataInEnable), 32'(q.size() != 0));
        chk("data",   DataIn, (q.size() != 0) ? q[0] : 32'h0);
        chk("ready",  32'(s_axis_tready), 32'(exp_ready()));
`ifdef AQ_DJPEG_INFIFO_STAT_EN
        chk("stat_bytes",    StatBytes, m_bytes);
        chk("stat_underrun", StatUnderrun, m_under);
`endif
    endtask

    task automatic model_reset();
        q.delete();
        mstate  = M_STREAM;
        mrun    = 1'b0;
        m_bytes = '0;
        m_under = '0;
    endtask

    // Apply the behavioural rules for the inputs present before the coming edge
    task automatic model_step();
        bit acc, endi, pop, push, clear, under_inc;
        int nxt;
        logic [31:0] w;
        logic [32:0] s;
        acc       = s_axis_tvalid && exp_ready();
        endi      = DataOutEnd && ProcessIdle;
        pop       = DataInRead && (q.size() > 0) && (mstate != M_FLUSH);
        under_inc = DataInReq && (q.size() == 0) && (mstate != M_FLUSH);
        w         = fill(s_axis_tdata, s_axis_tkeep);
        push      = 1'b0;
        clear     = 1'b0;
        nxt       = mstate;
        if (mstate == M_STREAM) begin
            if (acc && s_axis_tlast && endi) begin clear = 1; nxt = M_FLUSH; end
            else if (acc && s_axis_tlast) begin push = (s_axis_tkeep != 0); nxt = M_DRAIN; end
            else if (endi) begin clear = 1; nxt = M_DISCARD; end
            else push = acc && (s_axis_tkeep != 0);
        end else if (mstate == M_DRAIN) begin
            if (endi) begin clear = 1; nxt = M_FLUSH; end
        end else if (mstate == M_DISCARD) begin
            if (acc && s_axis_tlast) begin clear = 1; nxt = M_FLUSH; end
        end else begin
            clear = 1; nxt = M_STREAM;
        end
        if (clear) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(w);
        end
        if (nxt == M_FLUSH && mstate != M_FLUSH) begin
            m_bytes = '0;
            m_under = '0;
        end else begin
            if (push) begin
                s = {1'b0, m_bytes} + 33'($countones(s_axis_tkeep));
                m_bytes = s[32] ? 32'hFFFF_FFFF : s[31:0];
            end
            if (under_inc && m_under != 32'hFFFF_FFFF) m_under = m_under + 1;
        end
        mstate = nxt;
        mrun   = 1'b1;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_in();
        s_axis_tvalid = 0; s_axis_tlast = 0; s_axis_tkeep = 4'hF;
        DataInRead = 0; DataOutEnd = 0; ProcessIdle = 0; DataInReq = 0;
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] k, input logic l);
        s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tvalid = 1;
        cycle();
        s_axis_tvalid = 0; s_axis_tlast = 0;
        $display("push data=%h keep=%h last=%0d level=%0d", d, k, l, Level);
    endtask

    task automatic pop1();
        DataInRead = 1;
        cycle();
        DataInRead = 0;
        $display("pop level=%0d head=%h", Level, DataIn);
    endtask

    task automatic end_pulse();
        DataOutEnd = 1; ProcessIdle = 1;
        cycle();
        DataOutEnd = 0; ProcessIdle = 0;
        $display("end/idle pulse level=%0d ready=%0d", Level, s_axis_tready);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1;
        cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a_words [3];
        logic [31:0] nw;
        a_words[0] = 32'hE0FFD8FF;
        a_words[1] = 32'h11223344;
        a_words[2] = 32'h55667788;

        // Reset state
        idle_in();
        model_reset();
        #3;
        check_all();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("reset_ready", 32'(s_axis_tready), 32'h0);
        release_reset();

        // Three words in order, fall-through latency of one edge
        push(a_words[0], 4'hF, 0);
        chk("A_first", DataIn, 32'hE0FFD8FF);
        push(a_words[1], 4'hF, 0);
        push(a_words[2], 4'hF, 0);
        chk("A_level", 32'(Level), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("A_order", DataIn, a_words[i]);
            pop1();
        end
        chk("A_empty", 32'(DataInEnable), 32'd0);

        // Fill to capacity, check no same-cycle pop-to-ready path
        for (int i = 0; i < DEPTH; i++) push($urandom, 4'hF, 0);
        chk("B_level_full", 32'(Level), 32'd16);
        chk("B_ready_full", 32'(s_axis_tready), 32'd0);
        s_axis_tdata = $urandom; s_axis_tvalid = 1;
        cycle();
        s_axis_tvalid = 0;
        DataInRead = 1;
        #1;
        chk("B_ready_same", 32'(s_axis_tready), 32'd0);
        cycle();
        DataInRead = 0;
        chk("B_ready_next", 32'(s_axis_tready), 32'd1);
        for (int i = 0; i < DEPTH && q.size() > 0; i++) pop1();

        // Partial last beat padded with fill bytes, then drain and flush
        push($urandom, 4'hF, 0);
        push(32'hAABBD9FF, 4'b0011, 1);
        chk("C_drain_ready", 32'(s_axis_tready), 32'd0);
        pop1();
        chk("C_fill", DataIn, 32'hFFFFD9FF);
        pop1();
        end_pulse();
        chk("C_flush_ready", 32'(s_axis_tready), 32'd0);
        cycle();
        chk("C_stream_ready", 32'(s_axis_tready), 32'd1);

        // Flush with two words left
        for (int i = 0; i < 4; i++) push($urandom, 4'hF, i == 3);
        pop1();
        pop1();
        chk("C2_left", 32'(Level), 32'd2);
        end_pulse();
        chk("C2_flush_level", 32'(Level), 32'd0);
        chk("C2_flush_en", 32'(DataInEnable), 32'd0);
        cycle();
        chk("C2_ready", 32'(s_axis_tready), 32'd1);

        // End/idle before tlast: trailing beats dropped
        for (int i = 0; i < 5; i++) push($urandom, 4'hF, 0);
        end_pulse();
        for (int i = 5; i < 10; i++) begin
            push($urandom, 4'hF, i == 9);
            chk("D_discard_level", 32'(Level), 32'd0);
        end
        cycle();
        nw = $urandom;
        push(nw, 4'hF, 0);
        chk("D_next_image", DataIn, nw);
        pop1();

        // tlast together with end/idle: word not stored
        DataOutEnd = 1; ProcessIdle = 1;
        push($urandom, 4'hF, 1);
        DataOutEnd = 0; ProcessIdle = 0;
        chk("E_nowrite", 32'(Level), 32'd0);
        cycle();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            s_axis_tvalid = 1'($urandom_range(0, 1));
            s_axis_tdata  = $urandom;
            s_axis_tkeep  = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            s_axis_tlast  = ($urandom_range(0, 15) == 0);
            DataInRead    = 1'($urandom_range(0, 1));
            DataInReq     = 1'($urandom_range(0, 1));
            DataOutEnd    = ($urandom_range(0, 9) == 0);
            ProcessIdle   = 1'($urandom_range(0, 1));
            cycle();
            if (n % 50 == 0) $display("random step=%0d level=%0d ready=%0d", n, Level, s_axis_tready);
        end
        idle_in();
        cycle();

        // Reset asserted mid-image
        push($urandom, 4'hF, 0);
        push($urandom, 4'hF, 0);
        push($urandom, 4'hF, 0);
        rst = 0;
        #2;
        model_reset();
        check_all();
        chk("G_ready", 32'(s_axis_tready), 32'd0);
        chk("G_level", 32'(Level), 32'd0);
        release_reset();
        chk("G_ready_after", 32'(s_axis_tready), 32'd1);

`ifdef AQ_DJPEG_INFIFO_STAT_EN
        push($urandom, 4'hF, 0);
        push($urandom, 4'hF, 0);
        push($urandom, 4'hF, 0);
        push($urandom, 4'h1, 0);
        chk("S_bytes", StatBytes, 32'd13);
        for (int i = 0; i < 4; i++) pop1();
        DataInReq = 1;
        repeat (7) cycle();
        DataInReq = 0;
        chk("S_underrun", StatUnderrun, 32'd7);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
